// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for a NUM_DIGITS common-anode 7-segment display.
// Ports: clk/rst (sync, active-high); enable, blank_lz controls; load_valid/
//   load_data/load_dp/load_ready value load port; anode/seg/dp active-low pins;
//   frame_done one-cycle end-of-frame pulse.

// Hex nibble to active-low 7-segment pattern, seg[6]=a .. seg[0]=g.
// Latency: combinational.
// Backpressure: none.
module seg7_bcd_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end

endmodule

// Scans one digit per slot, with blank guard cycles between digits.
// Latency: anode/seg/dp registered, 1 cycle behind scanner state; frame_done combinational.
// Backpressure: one-entry pending buffer; load_ready low until it commits at a frame edge.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  // One counter serves both DRIVE and GUARD slots, so size it for the longer.
  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // Value and decimal-point mask travel together from load port to display.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] val;
    logic [NUM_DIGITS-1:0]   dpm;
  } disp_t;

  disp_t            pend_q;
  disp_t            disp_q;
  logic             pend_full;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             slot_end;
  logic             frame_end;
  logic             commit;
  logic             load_fire;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zeros_above;
  logic [NUM_DIGITS-1:0] anode_sel;
  logic [6:0]            dec_seg;
  logic                  lit;

  // ---------------------------------------------------------------------------
  // Scanner FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    slot_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_DRIVE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_nxt = '0;
          if (GUARD_CYC > 0) begin
            state_nxt = ST_GUARD;
          end else begin
            // No guard gap: the digit slot ends with its last drive cycle.
            slot_end = 1'b1;
            idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_DRIVE;
          slot_end  = 1'b1;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
    // Dropping enable parks the scanner from any state.
    if (!enable) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  // A frame only completes if the scanner is actually going to continue;
  // a disable in that same cycle parks it instead.
  assign frame_end  = slot_end && (idx == IDX_LAST) && enable && !rst;
  assign frame_done = frame_end;

  // ---------------------------------------------------------------------------
  // Load port: single pending slot, committed at frame boundaries or when parked
  // ---------------------------------------------------------------------------
  assign load_ready = !pend_full;
  assign load_fire  = load_valid && load_ready;
  assign commit     = pend_full && ((state == ST_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_q    <= '0;
      disp_q    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        disp_q <= pend_q;
      end
      // load_fire needs an empty slot and commit needs a full one, so the
      // two never coincide; a load in a commit cycle waits for the next edge.
      if (load_fire) begin
        pend_q    <= '{val: load_data, dpm: load_dp};
        pend_full <= 1'b1;
      end else if (commit) begin
        pend_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking, from the committed value only
  // ---------------------------------------------------------------------------
  always_comb begin
    lz_blank    = '0;
    zeros_above = 1'b1;
    // Walk down from the top digit; a digit is a leading zero while every
    // nibble from it upward is zero. Digit 0 is never blanked.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (disp_q.val[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz && zeros_above && !disp_q.dpm[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit select and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    anode_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = disp_q.val[4*i +: 4];
        cur_dp       = disp_q.dpm[i];
        cur_blank    = lz_blank[i];
        anode_sel[i] = 1'b0;
      end
    end
  end

  seg7_bcd_dec u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // enable gates the pins directly so the display goes dark on the first
  // cycle after enable drops, not one cycle later.
  assign lit = (state == ST_DRIVE) && enable && !cur_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      anode <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else if (lit) begin
      anode <= anode_sel;
      seg   <= dec_seg;
      dp    <= ~cur_dp;
    end else begin
      anode <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end
  end

  a_one_anode: assert property (@(posedge clk) disable iff (rst) $countones(~anode) <= 1);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int ND   = 4;
  localparam int RD   = 4;
  localparam int GC   = 1;
  localparam int SLOT = RD + GC;
  localparam int FRM  = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Active-low hex glyphs, a..g from MSB down.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: scanner position is just elapsed cycles since enable.
  bit          m_run   = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_disp  = 16'h0;
  logic [3:0]  m_ddp   = 4'h0;
  logic [15:0] m_pend  = 16'h0;
  logic [3:0]  m_pdp   = 4'h0;
  bit          m_pfull = 1'b0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYC   (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_ready (load_ready),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit blanked(int d, bit blz);
    return blz && (d > 0) && ((m_disp >> (4 * d)) == 16'h0) && !m_ddp[d];
  endfunction

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model, then check the registered pins after the edge.
  task automatic step(input bit r, input bit en, input bit blz, input bit lv,
                      input logic [15:0] ld, input logic [3:0] ldp);
    int         pos;
    int         dig;
    bit         fd;
    bit         lit;
    logic [3:0] nib;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    rst        = r;
    enable     = en;
    blank_lz   = blz;
    load_valid = lv;
    load_data  = ld;
    load_dp    = ldp;
    #1;
    pos = m_t % FRM;
    dig = pos / SLOT;
    fd  = !r && m_run && en && (pos == FRM - 1);
    chk("load_ready", 32'(load_ready), 32'(!m_pfull));
    chk("frame_done", 32'(frame_done), 32'(fd));

    lit   = !r && m_run && en && ((pos % SLOT) < RD) && !blanked(dig, blz);
    nib   = 4'(m_disp >> (4 * dig));
    e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
    e_seg = lit ? seg_tab[nib] : 7'h7F;
    e_dp  = lit ? ~m_ddp[dig] : 1'b1;

    if (r) begin
      m_run = 1'b0; m_t = 0; m_disp = '0; m_ddp = '0;
      m_pend = '0; m_pdp = '0; m_pfull = 1'b0;
    end else begin
      if (m_pfull) begin
        if (!m_run || fd) begin
          m_disp  = m_pend;
          m_ddp   = m_pdp;
          m_pfull = 1'b0;
        end
      end else if (lv) begin
        m_pend  = ld;
        m_pdp   = ldp;
        m_pfull = 1'b1;
      end
      m_t   = (m_run && en) ? m_t + 1 : 0;
      m_run = en;
    end

    @(posedge clk);
    #1;
    chk("anode", 32'(anode), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
  endtask

  initial begin
    bit          r;
    bit          en;
    bit          blz;
    bit          lv;
    logic [15:0] d;
    logic [3:0]  dm;

    rst = 1'b1; enable = 1'b0; blank_lz = 1'b0;
    load_valid = 1'b0; load_data = '0; load_dp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    // Load while parked, then scan it.
    step(0, 0, 0, 1, 16'h1234, 4'h0);
    step(0, 0, 0, 0, 16'h0, 4'h0);
    repeat (45) step(0, 1, 0, 0, 16'h0, 4'h0);

    // Leading-zero blanking of 0050.
    step(0, 1, 1, 1, 16'h0050, 4'h0);
    repeat (45) step(0, 1, 1, 0, 16'h0, 4'h0);

    // Mid-frame load with a second, ignored load behind it.
    step(0, 1, 0, 1, 16'h1234, 4'h0);
    repeat (25) step(0, 1, 0, 0, 16'h0, 4'h0);
    repeat (7) step(0, 1, 0, 0, 16'h0, 4'h0);
    step(0, 1, 0, 1, 16'hABCD, 4'h2);
    step(0, 1, 0, 1, 16'h5555, 4'hF);
    repeat (45) step(0, 1, 0, 0, 16'h0, 4'h0);

    // Enable dropped mid-frame, then re-enabled.
    repeat (12) step(0, 1, 0, 0, 16'h0, 4'h0);
    repeat (2) step(0, 0, 0, 0, 16'h0, 4'h0);
    repeat (30) step(0, 1, 0, 0, 16'h0, 4'h0);

    // Reset with a load pending: the load must be discarded.
    repeat (6) step(0, 1, 0, 0, 16'h0, 4'h0);
    step(0, 1, 0, 1, 16'h9999, 4'h5);
    step(1, 1, 0, 0, 16'h0, 4'h0);
    step(0, 0, 0, 0, 16'h0, 4'h0);
    repeat (25) step(0, 1, 0, 0, 16'h0, 4'h0);

    // Randomized traffic.
    en  = 1'b1;
    blz = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 299) == 0);
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) blz = !blz;
      lv = ($urandom_range(0, 7) == 0);
      d  = 16'($urandom);
      d  = d >> (4 * $urandom_range(0, 4));
      dm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(r, en, blz, lv, d, dm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
